// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - iterative shift-and-add unsigned multiplier, one multiplier bit per cycle
module seq_multiplier #(
    parameter int size = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [size-1:0]     in_a,
    input  logic [size-1:0]     in_b,
    output logic [2*size-1:0]   product,
    output logic                busy,
    output logic                done
);

    // Counter must hold values 0..size without wrapping.
    localparam int CW = $clog2(size + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [size-1:0] mcand;
    logic [size-1:0] hi;
    logic [size-1:0] lo;
    logic [CW-1:0]   cnt;

    logic [size:0]   sum;
    logic [size-1:0] hi_next;
    logic [size-1:0] lo_next;

    // One step: conditional add into hi keeping the carry, then shift {c,hi,lo} right by one.
    always_comb begin
        sum = {1'b0, hi};
        if (lo[0]) begin
            sum = {1'b0, hi} + {1'b0, mcand};
        end
        hi_next = sum[size:1];
        lo_next = {sum[0], lo[size-1:1]};
    end

    // Control FSM with datapath registers and registered busy/done flags.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= IDLE;
            mcand   <= '0;
            hi      <= '0;
            lo      <= '0;
            cnt     <= '0;
            product <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand <= in_a;
                        lo    <= in_b;
                        hi    <= '0;
                        cnt   <= '0;
                        state <= RUN;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    hi  <= hi_next;
                    lo  <= lo_next;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(size - 1)) begin
                        product <= {hi_next, lo_next};
                        state   <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        mcand <= in_a;
                        lo    <= in_b;
                        hi    <= '0;
                        cnt   <= '0;
                        state <= RUN;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// tb/tb_seq_multiplier.sv - self-checking bench for seq_multiplier
module tb_seq_multiplier;

    localparam int SIZE = 4;

    logic              clk;
    logic              reset_n;
    logic              start;
    logic [SIZE-1:0]   in_a;
    logic [SIZE-1:0]   in_b;
    logic [2*SIZE-1:0] product;
    logic              busy;
    logic              done;

    int n_vec;
    int n_err;

    seq_multiplier #(.size(SIZE)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .in_a    (in_a),
        .in_b    (in_b),
        .product (product),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference result: plain arithmetic on the operands.
    function automatic logic [2*SIZE-1:0] ref_mul(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b);
        return (2*SIZE)'(a) * (2*SIZE)'(b);
    endfunction

    task automatic test_reset();
        reset_n = 1'b0;
        start   = 1'b1;
        in_a    = 4'd5;
        in_b    = 4'd5;
        repeat (2) @(negedge clk);
        start   = 1'b0;
        n_vec++;
        if (product !== 8'd0) begin n_err++; $display("FAIL reset_product got=%0d exp=0", product); end
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_vec++;
        if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", done); end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 8'd0) begin
            n_err++; $display("FAIL idle_after_reset busy=%b done=%b product=%0d exp 0/0/0", busy, done, product);
        end
    endtask

    // Directed operand pairs, including the carry-heavy and zero corners.
    task automatic test_directed();
        logic [SIZE-1:0] ta [4];
        logic [SIZE-1:0] tb [4];
        logic [2*SIZE-1:0] exp;
        ta[0] = 4'd13; tb[0] = 4'd11;
        ta[1] = 4'd15; tb[1] = 4'd15;
        ta[2] = 4'd0;  tb[2] = 4'd9;
        ta[3] = 4'd9;  tb[3] = 4'd0;
        for (int t = 0; t < 4; t++) begin
            exp = ref_mul(ta[t], tb[t]);
            @(negedge clk);
            start = 1'b1; in_a = ta[t]; in_b = tb[t];
            @(negedge clk);
            start = 1'b0; in_a = SIZE'($urandom); in_b = SIZE'($urandom);
            for (int k = 0; k < SIZE; k++) begin
                if (k > 0) @(negedge clk);
                n_vec++;
                if (busy !== 1'b1 || done !== 1'b0) begin
                    n_err++; $display("FAIL dir%0d_busy cyc=%0d busy=%b done=%b exp 1/0", t, k, busy, done);
                end
            end
            @(negedge clk);
            n_vec++;
            if (done !== 1'b1 || busy !== 1'b0 || product !== exp) begin
                n_err++; $display("FAIL dir%0d_done done=%b busy=%b product=%0d exp 1/0/%0d", t, done, busy, product, exp);
            end
            repeat (2) @(negedge clk);
            n_vec++;
            if (done !== 1'b0 || busy !== 1'b0 || product !== exp) begin
                n_err++; $display("FAIL dir%0d_hold done=%b busy=%b product=%0d exp 0/0/%0d", t, done, busy, product, exp);
            end
        end
    endtask

    task automatic test_random();
        logic [SIZE-1:0]   a;
        logic [SIZE-1:0]   b;
        logic [2*SIZE-1:0] exp;
        for (int t = 0; t < 24; t++) begin
            a = SIZE'($urandom);
            b = SIZE'($urandom);
            exp = ref_mul(a, b);
            @(negedge clk);
            start = 1'b1; in_a = a; in_b = b;
            @(negedge clk);
            start = 1'b0; in_a = SIZE'($urandom); in_b = SIZE'($urandom);
            repeat (SIZE) @(negedge clk);
            n_vec++;
            if (done !== 1'b1 || product !== exp) begin
                n_err++; $display("FAIL rnd%0d a=%0d b=%0d done=%b product=%0d exp 1/%0d", t, a, b, done, product, exp);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_start_during_run();
        logic [SIZE-1:0]   a;
        logic [SIZE-1:0]   b;
        logic [2*SIZE-1:0] exp;
        a = SIZE'($urandom_range(4, 15));
        b = SIZE'($urandom_range(4, 15));
        exp = ref_mul(a, b);
        @(negedge clk);
        start = 1'b1; in_a = a; in_b = b;
        @(negedge clk);
        in_a = 4'd2; in_b = 4'd3;
        repeat (3) @(negedge clk);
        start = 1'b0;
        n_vec++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_err++; $display("FAIL run_ignore_busy busy=%b done=%b exp 1/0", busy, done);
        end
        @(negedge clk);
        n_vec++;
        if (done !== 1'b1 || product !== exp) begin
            n_err++; $display("FAIL run_ignore_result done=%b product=%0d exp 1/%0d", done, product, exp);
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_vec++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_err++; $display("FAIL run_ignore_no_second cyc=%0d done=%b busy=%b exp 0/0", k, done, busy);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [2*SIZE-1:0] exp1;
        exp1 = ref_mul(4'd3, 4'd10);
        @(negedge clk);
        start = 1'b1; in_a = 4'd3; in_b = 4'd10;
        @(negedge clk);
        start = 1'b0;
        repeat (SIZE) @(negedge clk);
        n_vec++;
        if (done !== 1'b1 || product !== exp1) begin
            n_err++; $display("FAIL b2b_first done=%b product=%0d exp 1/%0d", done, product, exp1);
        end
        start = 1'b1; in_a = 4'd7; in_b = 4'd6;
        for (int k = 1; k <= SIZE; k++) begin
            @(negedge clk);
            start = 1'b0; in_a = SIZE'($urandom); in_b = SIZE'($urandom);
            n_vec++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                n_err++; $display("FAIL b2b_busy cyc=%0d busy=%b done=%b exp 1/0", k, busy, done);
            end
        end
        @(negedge clk);
        n_vec++;
        if (done !== 1'b1 || product !== ref_mul(4'd7, 4'd6)) begin
            n_err++; $display("FAIL b2b_second done=%b product=%0d exp 1/42", done, product);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        start = 1'b1; in_a = 4'd12; in_b = 4'd12;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        start   = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        start   = 1'b0;
        n_vec++;
        if (product !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin
            n_err++; $display("FAIL abort_state product=%0d busy=%b done=%b exp 0/0/0", product, busy, done);
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_vec++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_err++; $display("FAIL abort_no_done cyc=%0d done=%b busy=%b exp 0/0", k, done, busy);
            end
        end
        start = 1'b1; in_a = 4'd5; in_b = 4'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (SIZE) @(negedge clk);
        n_vec++;
        if (done !== 1'b1 || product !== 8'd15) begin
            n_err++; $display("FAIL after_abort done=%b product=%0d exp 1/15", done, product);
        end
        @(negedge clk);
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        reset_n = 1'b0;
        start   = 1'b0;
        in_a    = '0;
        in_b    = '0;
        test_reset();
        test_directed();
        test_random();
        test_start_during_run();
        test_back_to_back();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 Parameter: size, default 4, operand width in bits (size >= 2).
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: reset_n  input  1  reset, synchronous and active-low.
REQ-004 Port: start  input  1  request to begin a multiply; sampled on each rising edge.
REQ-005 Port: in_a  input  size  multiplicand, unsigned.
REQ-006 Port: in_b  input  size  multiplier, unsigned.
REQ-007 Port: product  output  2*size  registered unsigned result in_a*in_b.
REQ-008 Port: busy  output  1  high while a multiply is in progress.
REQ-009 Port: done  output  1  one-cycle pulse; product valid and newly updated.

Function
REQ-010 Algorithm SHALL be iterative shift-and-add, one multiplier bit per cycle, using one size-bit adder with carry-out per step.
REQ-011 States SHALL be IDLE, RUN and DONE. Only these three states are legal.
REQ-012 IDLE: busy=0, done=0. start=1 at an edge SHALL latch in_a into the multiplicand register and in_b into the low accumulator. It SHALL clear the high accumulator and step counter, then go to RUN.
REQ-013 IDLE with start=0 SHALL stay in IDLE, and product SHALL hold.
REQ-014 RUN: busy=1, done=0. Each edge SHALL perform one step:
- if lo[0]=1, {c,hi} = hi + multiplicand (size-bit add, carry c kept), else c=0 and hi is unchanged;
- then {hi,lo} = {c,hi,lo} >> 1;
- counter increments.
REQ-015 After exactly size RUN edges, the FSM SHALL go to DONE and product SHALL load {hi,lo} on that same edge.
REQ-016 DONE: busy=0, done=1 for exactly one cycle. The next edge SHALL go to IDLE, or directly to RUN if start=1 (operands latched as in REQ-012).
REQ-017 Latency: start sampled at edge E. Then busy=1 for the size cycles following E, and done=1 in the cycle after edge E+size. Total size+1 cycles from start to done.
REQ-018 start during RUN SHALL be ignored. in_a and in_b changes after the start edge SHALL NOT affect the result in progress.
REQ-019 product SHALL change only on the edge entering DONE, or on reset. It SHALL hold between operations.
REQ-020 The step counter SHALL be ceil(log2(size+1)) bits wide and SHALL NOT wrap within an operation.
REQ-021 No overflow is possible: product width 2*size holds the maximum (2^size-1)^2. The carry-out of every step SHALL be shifted into hi and never discarded.
REQ-022 busy and done SHALL never both be 1. They SHALL be decoded from registered state only (no combinational path from start).

Reset
REQ-023 reset_n=0 at an edge SHALL force state=IDLE, product=0, busy=0, done=0, and clear counter, hi and lo. This applies in any state, including mid-RUN and in DONE.
REQ-024 Reset SHALL take priority over start on the same edge. An aborted multiply SHALL produce no done pulse.
REQ-025 After reset_n returns to 1, the first start SHALL behave per REQ-012.

Verification (size=4)
REQ-026 Reset then start with in_a=13, in_b=11 -> busy=1 for 4 cycles, then done pulse with product=143 (8'h8F); product holds 143 afterwards.
REQ-027 in_a=15, in_b=15 -> product=225 (8'hE1); checks the carry-out path of every step. Also in_a=0, in_b=9 -> product=0. Also in_a=9, in_b=0 -> product=0.
REQ-028 start=1 held for 3 consecutive cycles during RUN with in_a and in_b changed to 2 and 3 -> result still that of the first operands. No second done is generated until a new start is sampled in IDLE or DONE.
REQ-029 start=1 in the DONE cycle with in_a=7, in_b=6 -> busy rises on the next cycle with no IDLE gap. done pulses 5 cycles after the first done, with product=42.
REQ-030 reset_n=0 for one edge in the 2nd RUN cycle of 12*12 -> product=0, busy=0, no done. A subsequent start with in_a=5, in_b=3 -> product=15 with nominal latency.
